alu_2bit_cmd_queue: RTL
=======================

Name: alu_2bit_cmd_queue

Overview:
Command front-end for the 2-bit ALU datapath. Accepts (A, B, sel) commands over a valid/ready interface and buffers them in a small FIFO. Drives the head entry onto the combinational 2-bit ALU and registers the ALU result into an output stage with its own valid/ready handshake. Sits directly upstream of the ALU and also captures its output, so the ALU never sees unbuffered operands.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  command present on in_a/in_b/in_sel
in_ready  output  1  queue can accept a command this cycle
in_a  input  2  operand A
in_b  input  2  operand B
in_sel  input  3  operation select (000 add, 001 sub, 010 and, 011 or, 100 xor, others give 0)
alu_a  output  2  operand A to ALU
alu_b  output  2  operand B to ALU
alu_sel  output  3  select to ALU
alu_y  input  3  combinational ALU result
out_valid  output  1  result held in output register
out_ready  input  1  consumer accepts result
out_y  output  3  registered ALU result
out_sel  output  3  select that produced out_y

Behaviour:
- Reset (rst_n low at a clock edge): FIFO emptied (rd_ptr=wr_ptr=0, count=0); out_valid=0, out_y=0, out_sel=0. in_ready is 0 while rst_n is low and 1 after the first edge with rst_n high. Reset mid-transfer discards all queued and held commands; no partial result is emitted.
- Push: in_valid && in_ready at an edge writes the entry at wr_ptr and increments wr_ptr (mod DEPTH).
- in_ready = (count < DEPTH). It does not depend on the same-cycle pop, so there is no write-through when full.
- Head: when count > 0, alu_a/alu_b/alu_sel = the entry at rd_ptr. When empty, they are driven to 0/0/3'b111, so the ALU outputs 0.
- Capture condition cap = (count > 0) && (!out_valid || out_ready). On cap:
  - out_y <= alu_y, out_sel <= head sel, out_valid <= 1.
  - rd_ptr increments (mod DEPTH).
- Drain: out_valid && out_ready with no cap → out_valid <= 0; out_y and out_sel hold their last values.
- Simultaneous push and cap: count unchanged, both pointers advance. Push alone: count+1. Cap alone: count-1.
- Latency: command accepted at edge N (empty queue, idle output) → out_valid high after edge N+1. Sustained throughput is one command per cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 → out_y and out_sel stable, head not consumed, and the FIFO fills to DEPTH, then in_ready=0.
- Ordering strictly FIFO; no command dropped or duplicated.
- Arithmetic is performed in the ALU only. out_y is the 3-bit ALU value unmodified; for subtraction, 3-bit wraparound (e.g. 0-1 = 3'b111).

Optional Feature:
Macro ALU_CMD_QUEUE_FLAGS_EN.
- Defined: adds outputs out_zero (1 bit) and out_cout (1 bit), registered alongside out_y on cap.
  - out_zero = (alu_y == 0).
  - out_cout = alu_y[2] when head sel is 000 or 001 (carry/borrow); otherwise 0.
  - Both reset to 0 and hold when out_valid drops.
- Undefined: ports and registers absent; all other behaviour identical.

Test Plan:
- Reset then single push (A=2'b11, B=2'b01, sel=000), out_ready=1 → out_valid high one edge after the push edge; out_y=3'b100, out_sel=000 (flags: out_cout=1, out_zero=0).
- Push sub (A=0, B=1, sel=001) → out_y=3'b111 (flags: out_cout=1); then and (A=2, B=1, sel=010) → out_y=0 (flags: out_zero=1, out_cout=0).
- Hold out_ready=0 and push 5 commands with DEPTH=4 → first result held stable in the output register. Of the remaining four, all are queued with count reaching 4 and in_ready=0 afterwards. Release out_ready → results emerge in push order, one per cycle.
- Full queue with out_ready=1 and in_valid=1 every cycle → one push and one capture per cycle, count stays at DEPTH-1, no entry lost (check a sequence of 16 xor commands against a scoreboard).
- Invalid sel=3'b110 (A=3, B=3) → out_y=0 (flags: out_zero=1), out_sel=110.
- Assert rst_n=0 for one edge with 3 entries queued and out_valid=1 → next cycle out_valid=0, out_y=0, count=0; no queued result appears after reset releases.

Source files
------------

// File: rtl/alu_2bit_cmd_queue.sv
// rtl/alu_2bit_cmd_queue.sv - command FIFO feeding a 2-bit ALU with a registered, handshaked result stage
// Optional feature macro: ALU_CMD_QUEUE_FLAGS_EN adds out_zero/out_cout registered flags.
module alu_2bit_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_a,
  input  logic [1:0] in_b,
  input  logic [2:0] in_sel,
  output logic [1:0] alu_a,
  output logic [1:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [2:0] alu_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_y,
  output logic [2:0] out_sel
`ifdef ALU_CMD_QUEUE_FLAGS_EN
  ,
  output logic       out_zero,
  output logic       out_cout
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Entry layout: {a[1:0], b[1:0], sel[2:0]}
  logic [6:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             ready_en;
  logic             head_valid;
  logic             push;
  logic             cap;

  // ready_en keeps in_ready low until the first edge after reset releases
  assign head_valid = (count != '0);
  assign in_ready   = rst_n && ready_en && (count < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign cap        = head_valid && (!out_valid || out_ready);

  // Present the head entry to the ALU; an empty queue selects an invalid op so the ALU yields 0
  always_comb begin
    alu_a   = 2'b00;
    alu_b   = 2'b00;
    alu_sel = 3'b111;
    if (head_valid) begin
      alu_a   = mem[rd_ptr][6:5];
      alu_b   = mem[rd_ptr][4:3];
      alu_sel = mem[rd_ptr][2:0];
    end
  end

  // Command storage; needs no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_sel};
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (cap)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, cap})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Input side opens one edge after reset deasserts
  always_ff @(posedge clk) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Output register: capture the ALU result of the head, or drop valid once consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= 3'b000;
      out_sel   <= 3'b000;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_y     <= alu_y;
      out_sel   <= alu_sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_CMD_QUEUE_FLAGS_EN
  // Status flags travel with the result; carry/borrow only meaningful for add and sub
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
      out_cout <= 1'b0;
    end else if (cap) begin
      out_zero <= (alu_y == 3'b000);
      out_cout <= ((alu_sel == 3'b000) || (alu_sel == 3'b001)) ? alu_y[2] : 1'b0;
    end
  end
`endif

endmodule
